// File: rtl/uart_rx_cfg_if.sv
// Receive-side output bundle: one held frame with its error flags, valid/ready handshake.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS_MAX = 8
);
  logic                     m_valid;
  logic                     m_ready;
  logic [DATA_BITS_MAX-1:0] m_data;
  logic                     m_parity_err;
  logic                     m_frame_err;

  modport master (
    output m_valid, m_data, m_parity_err, m_frame_err,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_parity_err, m_frame_err,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: synchronised rx, 3-sample majority at mid-bit,
// parity/stop checking and a one-entry output register with overrun detection.
module uart_rx_cfg #(
  parameter int DATA_BITS_MAX = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          tick,
  input  logic          rx,
  input  logic [3:0]    cfg_data_bits,
  input  logic [1:0]    cfg_parity,
  input  logic          cfg_stop2,
  uart_rx_cfg_if.master m,
  output logic          overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HM1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_H    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_HP1  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BITS_MIN = 4'd5;
  localparam logic [3:0]    BITS_MAX = 4'(DATA_BITS_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  logic [SYNC_STAGES-1:0]   sync_q;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [3:0]               bit_q, bit_d;
  logic [3:0]               nbits_q, nbits_d;
  logic                     par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic                     stop2_q, stop2_d, stop_idx_q, stop_idx_d;
  logic                     s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS_MAX-1:0] sh_q, sh_d;
  logic                     par_q, par_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                     done;

  logic                     valid_q, perr_out_q, ferr_out_q, ovr_q;
  logic [DATA_BITS_MAX-1:0] data_q;

  logic                     rx_s, maj, at_mid, at_last, counting, stop_bad;
  logic [3:0]               cfg_bits_clamped;
  logic [DATA_BITS_MAX-1:0] bit_sel;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  // The third vote is the live sample taken at count H+1.
  assign maj      = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign at_mid   = (cnt_q == CNT_HP1);
  assign at_last  = (cnt_q == CNT_LAST);
  assign counting = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);
  assign stop_bad = ferr_q | ~maj;
  assign cfg_bits_clamped = (cfg_data_bits < BITS_MIN) ? BITS_MIN :
                            (cfg_data_bits > BITS_MAX) ? BITS_MAX : cfg_data_bits;

  generate
    for (genvar gi = 0; gi < DATA_BITS_MAX; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (bit_q == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      nbits_q    <= BITS_MIN;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      sh_q       <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    sh_d       = sh_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done       = 1'b0;
    if (tick) begin
      if (counting) cnt_d = at_last ? '0 : cnt_q + 1'b1;
      if (cnt_q == CNT_HM1) s0_d = rx_s;
      if (cnt_q == CNT_H)   s1_d = rx_s;
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d    = S_START;
            cnt_d      = '0;
            bit_d      = '0;
            stop_idx_d = 1'b0;
            nbits_d    = cfg_bits_clamped;
            par_en_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_odd_d  = (cfg_parity == 2'b10);
            stop2_d    = cfg_stop2;
            sh_d       = '0;
            par_d      = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
          end
        end
        S_START: begin
          if (at_mid && maj) state_d = S_IDLE;
          else if (at_last)  state_d = S_DATA;
        end
        S_DATA: begin
          if (at_mid) begin
            sh_d  = sh_q | (bit_sel & {DATA_BITS_MAX{maj}});
            par_d = par_q ^ maj;
          end
          if (at_last) begin
            if (bit_q == nbits_q - 4'd1) state_d = par_en_q ? S_PARITY : S_STOP;
            else                         bit_d   = bit_q + 4'd1;
          end
        end
        S_PARITY: begin
          if (at_mid)  perr_d  = ((par_q ^ maj) != par_odd_q);
          if (at_last) state_d = S_STOP;
        end
        S_STOP: begin
          // Finish at mid-bit of the last stop bit so a following start edge is not missed.
          if (at_mid) begin
            ferr_d = stop_bad;
            if (stop_idx_q == stop2_q) begin
              done    = 1'b1;
              state_d = stop_bad ? S_WAIT_HIGH : S_IDLE;
            end
          end
          if (at_last) stop_idx_d = 1'b1;
        end
        S_WAIT_HIGH: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done) begin
        if (!valid_q || m.m_ready) begin
          valid_q    <= 1'b1;
          data_q     <= sh_q;
          perr_out_q <= perr_q;
          ferr_out_q <= stop_bad;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && m.m_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m.m_valid      = valid_q;
  assign m.m_data       = data_q;
  assign m.m_parity_err = perr_out_q;
  assign m.m_frame_err  = ferr_out_q;
  assign overrun        = ovr_q;
endmodule
